// File: rtl/alu_issue_if.sv
// Decode-to-execute issue stage bus: upstream handshake + payload, downstream
// ALU32 operands and handshake, and the writeback snoop used for forwarding.
// master = the side driving the stage (decode / bench), slave = the stage itself.
interface alu_issue_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SEL_W  = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_rs1_val;
  logic [XLEN-1:0]   in_rs2_val;
  logic [XLEN-1:0]   in_imm;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [1:0]        in_src1;
  logic [1:0]        in_src2;
  logic [SEL_W-1:0]  in_alu_sel;
  logic [REG_AW-1:0] in_rd;
  logic              in_wen;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   alu_in1;
  logic [XLEN-1:0]   alu_in2;
  logic [SEL_W-1:0]  alu_sel;
  logic [XLEN-1:0]   out_pc;
  logic [REG_AW-1:0] out_rd;
  logic              out_wen;
  logic              wb_wen;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  modport master (
    output flush, in_valid, in_pc, in_rs1_val, in_rs2_val, in_imm, in_rs1, in_rs2,
           in_src1, in_src2, in_alu_sel, in_rd, in_wen, out_ready, wb_wen, wb_rd, wb_data,
    input  in_ready, out_valid, alu_in1, alu_in2, alu_sel, out_pc, out_rd, out_wen
  );

  modport slave (
    input  flush, in_valid, in_pc, in_rs1_val, in_rs2_val, in_imm, in_rs1, in_rs2,
           in_src1, in_src2, in_alu_sel, in_rd, in_wen, out_ready, wb_wen, wb_rd, wb_data,
    output in_ready, out_valid, alu_in1, alu_in2, alu_sel, out_pc, out_rd, out_wen
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage feeding ALU32. Two-entry skid buffer (main + skid)
// keeps in_ready a pure register while sustaining one instruction per cycle.
// Entries hold raw decoded fields; ALU operands are muxed from the main entry.
// Optional feature macro: ALU_ISSUE_FWD_EN enables writeback-snoop forwarding into
// captured and held rs1/rs2 values.
module alu_issue_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SEL_W  = 4
) (
  input logic         clk,
  input logic         rst,
  alu_issue_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [1:0]        src1;
    logic [1:0]        src2;
    logic [SEL_W-1:0]  sel;
    logic [REG_AW-1:0] rd;
    logic              wen;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;

  logic   in_fire, out_fire;
  entry_t in_entry, main_cur, skid_cur;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = main_valid_q & bus.out_ready;

`ifdef ALU_ISSUE_FWD_EN
  // Replace rs values whose register is being written back this cycle (x0 never forwards).
  function automatic entry_t fwd(entry_t e, logic wen, logic [REG_AW-1:0] rd,
                                 logic [XLEN-1:0] data);
    entry_t r;
    r = e;
    if (wen && (rd != '0)) begin
      if (e.rs1 == rd) r.rs1_val = data;
      if (e.rs2 == rd) r.rs2_val = data;
    end
    return r;
  endfunction
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.wb_wen, bus.wb_rd, bus.wb_data, main_q.rs1, main_q.rs2};
`endif

  // Build the incoming entry and the held entries as seen after this cycle's snoop.
  always_comb begin
    in_entry         = '0;
    in_entry.pc      = bus.in_pc;
    in_entry.rs1_val = bus.in_rs1_val;
    in_entry.rs2_val = bus.in_rs2_val;
    in_entry.imm     = bus.in_imm;
    in_entry.rs1     = bus.in_rs1;
    in_entry.rs2     = bus.in_rs2;
    in_entry.src1    = bus.in_src1;
    in_entry.src2    = bus.in_src2;
    in_entry.sel     = bus.in_alu_sel;
    in_entry.rd      = bus.in_rd;
    in_entry.wen     = bus.in_wen;
    main_cur         = main_q;
    skid_cur         = skid_q;
`ifdef ALU_ISSUE_FWD_EN
    in_entry = fwd(in_entry, bus.wb_wen, bus.wb_rd, bus.wb_data);
    if (main_valid_q) main_cur = fwd(main_q, bus.wb_wen, bus.wb_rd, bus.wb_data);
    if (skid_valid_q) skid_cur = fwd(skid_q, bus.wb_wen, bus.wb_rd, bus.wb_data);
`endif
  end

  // Entry movement; invalid entries are zeroed so idle outputs read as zero.
  always_comb begin
    main_d       = main_cur;
    skid_d       = skid_cur;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      main_d       = '0;
      skid_d       = '0;
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire && skid_valid_q) begin
      main_d = skid_cur;
      if (in_fire) begin
        skid_d = in_entry;
      end else begin
        skid_d       = '0;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire && (!main_valid_q || out_fire) && !skid_valid_q) begin
      main_d       = in_entry;
      main_valid_d = 1'b1;
    end else if (in_fire && main_valid_q && !out_fire) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end else if (out_fire) begin
      main_d       = '0;
      main_valid_d = 1'b0;
    end
    in_ready_d = ~skid_valid_d;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Operand muxes and main-entry outputs toward ALU32 / writeback.
  always_comb begin
    unique case (main_q.src1)
      2'b00:   bus.alu_in1 = main_q.rs1_val;
      2'b01:   bus.alu_in1 = main_q.pc;
      default: bus.alu_in1 = '0;
    endcase
    unique case (main_q.src2)
      2'b00:   bus.alu_in2 = main_q.rs2_val;
      2'b01:   bus.alu_in2 = main_q.imm;
      2'b10:   bus.alu_in2 = XLEN'(4);
      default: bus.alu_in2 = '0;
    endcase
    bus.alu_sel   = main_q.sel;
    bus.out_pc    = main_q.pc;
    bus.out_rd    = main_q.rd;
    bus.out_wen   = main_q.wen;
    bus.out_valid = main_valid_q;
    bus.in_ready  = in_ready_q;
  end

endmodule
